// File: rtl/icache_ctrl.sv
// Direct-mapped 8-set instruction cache: lookup, storage and line fill.
// Hits answer combinationally; misses fetch a 32-byte line from pmem.
module icache_ctrl #(
  parameter int S      = 8,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic [31:0]       mem_address,
  output logic              mem_resp,
  output logic [31:0]       mem_rdata,
  output logic              pmem_read,
  output logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state, state_n;

  logic [S-1:0]      valid;
  logic [23:0]       tag  [S];
  logic [LINE_W-1:0] data [S];

  logic [2:0]        rindex, windex, fidx;
  logic [23:0]       ftag;
  logic              load, bypass, hit;
  logic              rvalid;
  logic [23:0]       rtag;
  logic [LINE_W-1:0] rline;
  logic              addr_unused;

  assign addr_unused = ^mem_address[1:0];

  assign rindex = mem_address[7:5];
  assign windex = fidx;

  // Write bypass: a line being loaded is visible at its index this cycle.
  assign bypass = load && (rindex == windex);
  assign rvalid = bypass ? 1'b1 : valid[rindex];
  assign rtag   = bypass ? ftag : tag[rindex];
  assign rline  = bypass ? pmem_rdata : data[rindex];

  assign hit = mem_read && rvalid && (rtag == mem_address[31:8]);

  assign mem_rdata = rline[{mem_address[4:2], 5'b0} +: 32];

  always_comb begin
    state_n      = state;
    load         = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    unique case (state)
      IDLE: begin
        mem_resp = hit;
        if (mem_read && !hit) state_n = FETCH;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {ftag, fidx, 5'b0};
        if (pmem_resp) begin
          load    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fidx       <= '0;
      ftag       <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      valid      <= '0;
      for (int i = 0; i < S; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (state == IDLE && mem_read && !hit) begin
        fidx       <= rindex;
        ftag       <= mem_address[31:8];
        miss_count <= miss_count + 32'd1;
      end
      if (state == IDLE && hit)
        hit_count <= hit_count + 32'd1;
      if (load) begin
        valid[windex] <= 1'b1;
        tag[windex]   <= ftag;
        data[windex]  <= pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: misses, hits, eviction,
// reset during fill, dropped requests and stray memory responses.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0;
  logic [31:0]  mem_address = '0;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_chk = 0;
  int n_fail = 0;

  icache_ctrl #(.S(8), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_read = 1'b0;
    pmem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Miss on addr, memory answers on the 2nd FETCH cycle; reports the
  // fill address and the response seen in the first IDLE cycle after.
  task automatic fill_line(input logic [31:0] addr,
                           input logic [31:0] base,
                           output logic [31:0] pa,
                           output logic resp,
                           output logic [31:0] rd);
    mem_address = addr;
    mem_read = 1'b1;
    tick();
    mid();
    pa = pmem_address;
    tick();
    pmem_rdata = mkline(base);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    mid();
    resp = mem_resp;
    rd = mem_rdata;
    tick();
    mem_read = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mid();
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL rst_resp got %b want 0", mem_resp); end
    n_chk++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", mem_rdata); end
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL rst_pread got %b want 0", pmem_read); end
    n_chk++; if (pmem_address !== 32'h0) begin n_fail++; $display("FAIL rst_paddr got %h want 0", pmem_address); end
    n_chk++; if (hit_count !== 32'h0) begin n_fail++; $display("FAIL rst_hits got %0d want 0", hit_count); end
    n_chk++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL rst_miss got %0d want 0", miss_count); end
    mem_address = 32'h0;
    mem_read = 1'b1;
    #1;
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL rst_invalid got %b want 0", mem_resp); end
    mem_read = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    mem_address = 32'h0000_0124;
    mem_read = 1'b1;
    mid();
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL cold_t_resp got %b want 0", mem_resp); end
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL cold_t_pread got %b want 0", pmem_read); end
    tick();
    mid();
    n_chk++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL cold_pread got %b want 1", pmem_read); end
    n_chk++; if (pmem_address !== 32'h120) begin n_fail++; $display("FAIL cold_paddr got %h want 120", pmem_address); end
    n_chk++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL cold_miss got %0d want 1", miss_count); end
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL cold_fetch_resp got %b want 0", mem_resp); end
    tick();
    tick();
    pmem_rdata = mkline(32'h100);
    pmem_resp = 1'b1;
    mid();
    n_chk++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL cold_pread_f got %b want 1", pmem_read); end
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL cold_resp_f got %b want 0", mem_resp); end
    tick();
    pmem_resp = 1'b0;
    mid();
    n_chk++; if (mem_resp !== 1'b1) begin n_fail++; $display("FAIL cold_resp got %b want 1", mem_resp); end
    n_chk++; if (mem_rdata !== 32'h101) begin n_fail++; $display("FAIL cold_rdata got %h want 101", mem_rdata); end
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL cold_pread_drop got %b want 0", pmem_read); end
    tick();
    mem_read = 1'b0;
    n_chk++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL cold_hits got %0d want 1", hit_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    logic [31:0] h0;
    addrs[0] = 32'h120; exps[0] = 32'h100;
    addrs[1] = 32'h13C; exps[1] = 32'h107;
    addrs[2] = 32'h128; exps[2] = 32'h102;
    h0 = hit_count;
    mem_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_address = addrs[i];
      mid();
      n_chk++; if (mem_resp !== 1'b1) begin n_fail++; $display("FAIL b2b_resp%0d got %b want 1", i, mem_resp); end
      n_chk++; if (mem_rdata !== exps[i]) begin n_fail++; $display("FAIL b2b_rdata%0d got %h want %h", i, mem_rdata, exps[i]); end
      n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL b2b_pread%0d got %b want 0", i, pmem_read); end
      tick();
    end
    mem_read = 1'b0;
    n_chk++; if (hit_count !== h0 + 32'd3) begin n_fail++; $display("FAIL b2b_hits got %0d want %0d", hit_count, h0 + 3); end
    n_chk++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL b2b_miss got %0d want 1", miss_count); end
  endtask

  task automatic test_conflict();
    logic [31:0] pa, rd;
    logic resp;
    do_reset();
    fill_line(32'h0000_0120, 32'h100, pa, resp, rd);
    n_chk++; if (pa !== 32'h120) begin n_fail++; $display("FAIL evict_pa0 got %h want 120", pa); end
    fill_line(32'h0000_1120, 32'h200, pa, resp, rd);
    n_chk++; if (pa !== 32'h1120) begin n_fail++; $display("FAIL evict_pa1 got %h want 1120", pa); end
    n_chk++; if ({resp, rd} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL evict_rd1 got %b/%h want 1/200", resp, rd); end
    fill_line(32'h0000_0120, 32'h180, pa, resp, rd);
    n_chk++; if (pa !== 32'h120) begin n_fail++; $display("FAIL evict_pa2 got %h want 120", pa); end
    n_chk++; if ({resp, rd} !== {1'b1, 32'h180}) begin n_fail++; $display("FAIL evict_rd2 got %b/%h want 1/180", resp, rd); end
    n_chk++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL evict_miss got %0d want 3", miss_count); end
  endtask

  task automatic test_reset_mid_fill();
    mem_address = 32'h0000_0044;
    mem_read = 1'b1;
    tick();
    tick();
    pmem_rdata = mkline(32'h300);
    pmem_resp = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pmem_resp = 1'b0;
    mid();
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL rmf_pread got %b want 0", pmem_read); end
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL rmf_resp got %b want 0", mem_resp); end
    n_chk++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL rmf_hits got %0d want 0", hit_count); end
    n_chk++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL rmf_miss got %0d want 0", miss_count); end
    tick();
    mid();
    n_chk++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL rmf_refetch got %b want 1", pmem_read); end
    n_chk++; if (pmem_address !== 32'h40) begin n_fail++; $display("FAIL rmf_paddr got %h want 40", pmem_address); end
    n_chk++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL rmf_miss2 got %0d want 1", miss_count); end
    tick();
    pmem_rdata = mkline(32'h300);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    mid();
    n_chk++; if ({mem_resp, mem_rdata} !== {1'b1, 32'h301}) begin n_fail++; $display("FAIL rmf_fill got %b/%h want 1/301", mem_resp, mem_rdata); end
    tick();
    mem_read = 1'b0;
  endtask

  task automatic test_dropped_request();
    logic [31:0] h0, m0;
    m0 = miss_count;
    mem_address = 32'h0000_0064;
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    mid();
    n_chk++; if (pmem_address !== 32'h60) begin n_fail++; $display("FAIL drop_paddr got %h want 60", pmem_address); end
    tick();
    pmem_rdata = mkline(32'h400);
    pmem_resp = 1'b1;
    mid();
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL drop_resp_f got %b want 0", mem_resp); end
    tick();
    pmem_resp = 1'b0;
    mid();
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL drop_resp got %b want 0", mem_resp); end
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL drop_pread got %b want 0", pmem_read); end
    h0 = hit_count;
    tick();
    mem_address = 32'h0000_007C;
    mem_read = 1'b1;
    mid();
    n_chk++; if ({mem_resp, mem_rdata} !== {1'b1, 32'h407}) begin n_fail++; $display("FAIL drop_hit got %b/%h want 1/407", mem_resp, mem_rdata); end
    tick();
    mem_read = 1'b0;
    n_chk++; if (hit_count !== h0 + 32'd1) begin n_fail++; $display("FAIL drop_hits got %0d want %0d", hit_count, h0 + 1); end
    n_chk++; if (miss_count !== m0 + 32'd1) begin n_fail++; $display("FAIL drop_miss got %0d want %0d", miss_count, m0 + 1); end
  endtask

  task automatic test_stray_response();
    logic [31:0] h0, m0;
    h0 = hit_count;
    m0 = miss_count;
    mem_read = 1'b0;
    pmem_rdata = mkline(32'hDEAD_0000);
    pmem_resp = 1'b1;
    mid();
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL stray_pread got %b want 0", pmem_read); end
    tick();
    pmem_resp = 1'b0;
    tick();
    n_chk++; if (hit_count !== h0) begin n_fail++; $display("FAIL stray_hits got %0d want %0d", hit_count, h0); end
    n_chk++; if (miss_count !== m0) begin n_fail++; $display("FAIL stray_miss got %0d want %0d", miss_count, m0); end
    mem_address = 32'h0000_0064;
    mem_read = 1'b1;
    mid();
    n_chk++; if ({mem_resp, mem_rdata} !== {1'b1, 32'h401}) begin n_fail++; $display("FAIL stray_line got %b/%h want 1/401", mem_resp, mem_rdata); end
    tick();
    mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_reset_mid_fill();
    test_dropped_request();
    test_stray_response();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
